memfifo_test_check: RTL

Checker for the memfifo test-data stream, on the readback side of the DRAM FIFO. It consumes 128-bit words from the FIFO output and locks onto the test pattern produced by the memfifo test generator. It then verifies every word's counter sequence, sync bits and checksum, and reports lock state plus good/bad word counts for LEDs and host status. It accepts one word per clock and has no back-pressure other than reset.

---
 rtl/memfifo_test_pkg.sv | 23 ++
 rtl/memfifo_test_word.sv | 43 ++++
 rtl/memfifo_test_check.sv | 118 +++++++++++
 3 files changed

// File: rtl/memfifo_test_pkg.sv
// Shared constants, state encoding and pattern helper for the memfifo test-data checker.
package memfifo_test_pkg;

  localparam int unsigned CS_INIT   = 47;
  localparam int unsigned CS_W      = 14;
  localparam int unsigned WORD_W    = 128;
  localparam int unsigned RUN_W     = 4;
  localparam logic [6:0]  CNT_STEP  = 7'd111;
  localparam logic [15:0] SYNC_MASK = 16'hEAAA;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Expected byte k (0..14) of a word whose byte-0 counter field is c0.
  function automatic logic [7:0] exp_byte(input logic [6:0] c0, input logic [3:0] k);
    logic [6:0] cnt;
    cnt = c0 + CNT_STEP * 7'(k);
    return {SYNC_MASK[k], cnt};
  endfunction

endpackage

// File: rtl/memfifo_test_word.sv
// Stage 1: per-word self-consistency check (sync bits, counter steps, checksum).
module memfifo_test_word
  import memfifo_test_pkg::*;
(
  input  logic              ifclk,
  input  logic              reset,
  input  logic [WORD_W-1:0] din,
  input  logic              din_valid,
  output logic              self_ok,
  output logic [6:0]        c0,
  output logic              valid
);

  logic [14:0]     byte_ok_c;
  logic [CS_W-1:0] cs_c;
  logic [6:0]      chk_c;
  logic            self_ok_c;

  // Bytes 0..14 must match the pattern seeded by their own byte-0 counter field.
  always_comb begin
    byte_ok_c = '0;
    cs_c      = CS_W'(CS_INIT);
    for (int k = 0; k < 15; k++) begin
      byte_ok_c[k] = (din[8*k +: 8] == exp_byte(din[6:0], 4'(k)));
      cs_c         = cs_c + CS_W'(din[8*k +: 8]);
    end
    chk_c     = cs_c[6:0] ^ cs_c[13:7];
    self_ok_c = (&byte_ok_c) && din[127] && (din[126:120] == chk_c);
  end

  always_ff @(posedge ifclk) begin
    if (reset) begin
      valid   <= 1'b0;
      self_ok <= 1'b0;
      c0      <= '0;
    end else begin
      valid   <= din_valid;
      self_ok <= self_ok_c;
      c0      <= din[6:0];
    end
  end

endmodule

// File: rtl/memfifo_test_check.sv
// Readback checker for the memfifo test stream: lock onto the pattern, count good and bad words.
module memfifo_test_check
  import memfifo_test_pkg::*;
#(
  parameter int unsigned LOSS_THRESHOLD = 4,
  parameter int unsigned CNT_W          = 32
) (
  input  logic              ifclk,
  input  logic              reset,
  input  logic [WORD_W-1:0] DI,
  input  logic              DI_valid,
  output logic              DI_ready,
  input  logic              clear,
  output logic              locked,
  output logic [CNT_W-1:0]  word_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              err_sticky,
  output logic [3:0]        status
);

  state_t           state, state_nx;
  logic [6:0]       exp_c0, exp_c0_nx;
  logic [RUN_W-1:0] bad_run, bad_run_nx;
  logic             s1_valid, s1_ok;
  logic [6:0]       s1_c0;
  logic             good_c, word_inc_c, err_inc_c;

  memfifo_test_word u_word (
    .ifclk     (ifclk),
    .reset     (reset),
    .din       (DI),
    .din_valid (DI_valid && DI_ready),
    .self_ok   (s1_ok),
    .c0        (s1_c0),
    .valid     (s1_valid)
  );

  assign good_c = s1_ok && (s1_c0 == exp_c0);

  // State register.
  always_ff @(posedge ifclk) begin
    if (reset) begin
      state   <= HUNT;
      exp_c0  <= '0;
      bad_run <= '0;
    end else begin
      state   <= state_nx;
      exp_c0  <= exp_c0_nx;
      bad_run <= bad_run_nx;
    end
  end

  // Next state: lock on a self-consistent word, drop lock after a run of bad words.
  always_comb begin
    state_nx   = state;
    exp_c0_nx  = exp_c0;
    bad_run_nx = bad_run;
    if (s1_valid) begin
      case (state)
        HUNT: begin
          if (s1_ok) begin
            state_nx   = LOCKED;
            exp_c0_nx  = s1_c0 + 7'd1;
            bad_run_nx = '0;
          end
        end
        LOCKED: begin
          exp_c0_nx = exp_c0 + 7'd1;
          if (good_c) begin
            bad_run_nx = '0;
          end else if (bad_run == RUN_W'(LOSS_THRESHOLD - 1)) begin
            state_nx   = HUNT;
            bad_run_nx = '0;
          end else begin
            bad_run_nx = bad_run + RUN_W'(1);
          end
        end
        default: state_nx = HUNT;
      endcase
    end
  end

  // Counter strobes.
  always_comb begin
    word_inc_c = 1'b0;
    err_inc_c  = 1'b0;
    if (s1_valid) begin
      word_inc_c = (state == LOCKED) || s1_ok;
      err_inc_c  = (state == LOCKED) && !good_c;
    end
  end

  // Registered outputs; clear beats a same-cycle increment, counters saturate.
  always_ff @(posedge ifclk) begin
    if (reset) begin
      DI_ready   <= 1'b0;
      locked     <= 1'b0;
      status     <= '0;
      word_cnt   <= '0;
      err_cnt    <= '0;
      err_sticky <= 1'b0;
    end else begin
      DI_ready <= 1'b1;
      locked   <= (state_nx == LOCKED);
      status   <= {state_nx == LOCKED, bad_run_nx[2:0]};
      if (clear) begin
        word_cnt   <= '0;
        err_cnt    <= '0;
        err_sticky <= 1'b0;
      end else begin
        if (word_inc_c && !(&word_cnt)) word_cnt <= word_cnt + CNT_W'(1);
        if (err_inc_c && !(&err_cnt))   err_cnt  <= err_cnt + CNT_W'(1);
        if (err_inc_c)                  err_sticky <= 1'b1;
      end
    end
  end

endmodule
